// File: rtl/battle_turn_ctl.sv
// Game-control FSM: mouse-to-cell mapping, ship placement, turn-based shooting handshake, hit counting, win/lose.
// Optional aiming watchdog compiled in with `define AIM_TIMEOUT_EN.
module battle_turn_ctl #(
   parameter int GRID_N         = 10,
   parameter int CELL_W         = 32,
   parameter int ORIGIN_X       = 96,
   parameter int ORIGIN_Y       = 193,
   parameter int SHIPS_N        = 10,
   parameter int HITS_TO_WIN    = 20,
   parameter int TIMEOUT_FRAMES = 600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        start_button,
   input  logic        mouse_left,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic [3:0]  ship_count,
   input  logic        first_player,
   input  logic        opp_shot_valid,
   input  logic        opp_shot_hit,
   input  logic        shot_ack,
   input  logic        shot_hit,
   output logic [7:0]  mouse_position,
   output logic        pick_ship,
   output logic        pick_place,
   output logic        shot_req,
   output logic [7:0]  shot_pos,
   output logic [7:0]  hits_mine,
   output logic [7:0]  hits_theirs,
   output logic        win,
   output logic        lose,
   output logic [3:0]  state_led
);

   localparam logic [3:0] S_IDLE  = 4'b0001;
   localparam logic [3:0] S_PLACE = 4'b0010;
   localparam logic [3:0] S_WAIT  = 4'b0100;
   localparam logic [3:0] S_AIM   = 4'b1000;
   localparam logic [3:0] S_SHOT  = 4'b1001;
   localparam logic [3:0] S_WIN   = 4'b1111;
   localparam logic [3:0] S_LOSE  = 4'b1110;

   localparam int          CELL_SH = $clog2(CELL_W);
   localparam logic [12:0] X_LO    = 13'(ORIGIN_X);
   localparam logic [12:0] X_HI    = 13'(ORIGIN_X + GRID_N * CELL_W);
   localparam logic [12:0] Y_LO    = 13'(ORIGIN_Y);
   localparam logic [12:0] Y_HI    = 13'(ORIGIN_Y + GRID_N * CELL_W);
   localparam logic [4:0]  SHIPS_L = 5'(SHIPS_N);
   localparam logic [7:0]  HITS_L  = 8'(HITS_TO_WIN);

   if (GRID_N < 2 || GRID_N > 15 || HITS_TO_WIN < 1 || HITS_TO_WIN > 255 ||
       TIMEOUT_FRAMES < 1 || CELL_W != (1 << CELL_SH)) begin : g_param_check
      $error("battle_turn_ctl: illegal parameter combination");
   end

   logic [3:0]  state;
   logic        mouse_left_q;
   logic        click;
   logic        on_board;
   logic        in_grid;
   logic [11:0] dx;
   logic [11:0] dy;
   logic [7:0]  cell_pos;
   logic [7:0]  mine_inc;
   logic [7:0]  theirs_inc;
   logic        timeout_fire;

   // Bounds test in 13 bits first; the 12-bit subtraction is then known not to wrap.
   always_comb begin
      in_grid  = ({1'b0, mouse_xpos} >= X_LO) && ({1'b0, mouse_xpos} < X_HI) &&
                 ({1'b0, mouse_ypos} >= Y_LO) && ({1'b0, mouse_ypos} < Y_HI);
      dx       = mouse_xpos - 12'(ORIGIN_X);
      dy       = mouse_ypos - 12'(ORIGIN_Y);
      cell_pos = 8'hFF;
      if (in_grid) begin
         cell_pos = {4'(dy >> CELL_SH), 4'(dx >> CELL_SH)};
      end
   end

   assign click      = mouse_left & ~mouse_left_q;
   assign on_board   = (mouse_position != 8'hFF);
   assign pick_ship  = (state == S_PLACE) & click & on_board;
   assign state_led  = state;
   assign mine_inc   = (hits_mine == 8'hFF) ? 8'hFF : hits_mine + 8'd1;
   assign theirs_inc = (hits_theirs == 8'hFF) ? 8'hFF : hits_theirs + 8'd1;

`ifdef AIM_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_FRAMES - 1);
   logic [15:0] tmo_cnt;

   // Counter is held at zero outside AIM, so every AIM entry starts a fresh window.
   always_ff @(posedge clk) begin
      if (rst || state != S_AIM) begin
         tmo_cnt <= '0;
      end else if (frame_tick) begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end

   assign timeout_fire = frame_tick && (tmo_cnt == TMO_LAST);
`else
   assign timeout_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         mouse_left_q   <= 1'b0;
         mouse_position <= 8'hFF;
         pick_place     <= 1'b0;
         shot_req       <= 1'b0;
         shot_pos       <= 8'hFF;
         hits_mine      <= '0;
         hits_theirs    <= '0;
         win            <= 1'b0;
         lose           <= 1'b0;
      end else begin
         mouse_left_q <= mouse_left;
         pick_place   <= 1'b0;
         if (frame_tick) begin
            mouse_position <= cell_pos;
         end

         case (state)
            S_IDLE: begin
               if (start_button) begin
                  state <= S_PLACE;
               end
            end

            S_PLACE: begin
               if ({1'b0, ship_count} >= SHIPS_L) begin
                  state <= first_player ? S_AIM : S_WAIT;
               end
            end

            S_WAIT: begin
               if (opp_shot_valid) begin
                  if (opp_shot_hit) begin
                     hits_theirs <= theirs_inc;
                     if (theirs_inc == HITS_L) begin
                        state <= S_LOSE;
                        lose  <= 1'b1;
                     end
                  end else begin
                     state <= S_AIM;
                  end
               end
            end

            S_AIM: begin
               if (click && on_board) begin
                  shot_pos   <= mouse_position;
                  pick_place <= 1'b1;
                  state      <= S_SHOT;
               end else if (timeout_fire) begin
                  shot_pos <= 8'hFF;
                  state    <= S_SHOT;
               end
            end

            // shot_req rises on the first SHOT cycle, one cycle after pick_place.
            S_SHOT: begin
               if (shot_req && shot_ack) begin
                  shot_req <= 1'b0;
                  if (shot_hit) begin
                     hits_mine <= mine_inc;
                     if (mine_inc == HITS_L) begin
                        state <= S_WIN;
                        win   <= 1'b1;
                     end else begin
                        state <= S_AIM;
                     end
                  end else begin
                     state <= S_WAIT;
                  end
               end else begin
                  shot_req <= 1'b1;
               end
            end

            S_WIN, S_LOSE: begin
               if (start_button) begin
                  state       <= S_IDLE;
                  hits_mine   <= '0;
                  hits_theirs <= '0;
                  win         <= 1'b0;
                  lose        <= 1'b0;
                  shot_pos    <= 8'hFF;
               end
            end

            default: begin
               state    <= S_IDLE;
               shot_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/battle_turn_ctl.md
# battle_turn_ctl

Parametrised game-control state machine for the two-player ship game: it converts mouse coordinates to board cells, sequences ship placement, alternates shooting turns with the opponent over a request/acknowledge handshake, counts hits on both sides and declares win/lose. It sits between the mouse/VGA front end and the board memory and inter-board link, and replaces the fixed-size 4-state controller with a configurable board geometry and a complete game cycle.

## Interface
Parameters:
- GRID_N, 10: cells per board side; 2..15.
- CELL_W, 32: cell size in pixels; power of two.
- ORIGIN_X, 96: pixel x of the board's left edge.
- ORIGIN_Y, 193: pixel y of the board's top edge.
- SHIPS_N, 10: ships to place before play starts.
- HITS_TO_WIN, 20: hits needed to win; 1..255.
- TIMEOUT_FRAMES, 600: aiming watchdog length in frames; used only with the watchdog compiled in.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_tick  in  1  one-cycle pulse at hcount==0 and vcount==0.
- start_button  in  1  starts a game, or returns to IDLE after game over.
- mouse_left  in  1  left button level.
- mouse_xpos, mouse_ypos  in  12 each  pointer pixel coordinates.
- ship_count  in  4  ships already placed, from the board.
- first_player  in  1  sampled on leaving PLACE; 1 means we shoot first.
- opp_shot_valid  in  1  one-cycle pulse: opponent shot resolved on our board.
- opp_shot_hit  in  1  qualifies opp_shot_valid.
- shot_ack  in  1  link accepted our shot; shot_hit is valid in the same cycle.
- shot_hit  in  1  our shot hit.
- mouse_position  out  8  {row[7:4], col[3:0]}; 8'hFF when the pointer is off the board.
- pick_ship  out  1  one-cycle placement strobe.
- pick_place  out  1  one-cycle shot-selection strobe.
- shot_req  out  1  shot request, level.
- shot_pos  out  8  cell fired at; 8'hFF marks a pass.
- hits_mine, hits_theirs  out  8 each  hit counters.
- win, lose  out  1 each  game-over flags.
- state_led  out  4  state indicator.

## Operation
- Cell mapping is registered only on frame_tick. in_grid holds when ORIGIN_X ≤ x < ORIGIN_X+GRID_N*CELL_W and ORIGIN_Y ≤ y < ORIGIN_Y+GRID_N*CELL_W.
  - When in_grid: row = (y−ORIGIN_Y)>>log2(CELL_W) and col = (x−ORIGIN_X)>>log2(CELL_W). Subtraction is done in 12 bits after the bounds test, so it never wraps.
  - Otherwise: 8'hFF.
- click = mouse_left rising edge, with the previous level registered every cycle.
- The FSM advances every clk.
- States and state_led values:
  - IDLE (0001): start_button → PLACE. Counters, win and lose clear on entry.
  - PLACE (0010): pick_ship = click & mouse_position≠FF. When ship_count ≥ SHIPS_N, go to AIM if first_player else WAIT.
  - WAIT (0100): on opp_shot_valid, hits_theirs += opp_shot_hit. If the new value equals HITS_TO_WIN → LOSE; else if hit, stay in WAIT (opponent shoots again); else → AIM.
  - AIM (1000): on click & on-board, shot_pos ← mouse_position, pick_place pulses for one cycle, → SHOT. Off-board clicks are ignored.
  - SHOT (1001): shot_req = 1 until shot_ack. On ack, hits_mine += shot_hit. If the new value equals HITS_TO_WIN → WIN; else if hit → AIM (shoot again); else → WAIT.
  - WIN (1111) / LOSE (1110): win or lose held at 1. start_button → IDLE.
- Counters saturate at 255.
- opp_shot_valid outside WAIT is ignored. shot_ack outside SHOT is ignored.

## Timing
- Reset values:
  - State IDLE; state_led 0001.
  - mouse_position 8'hFF; shot_pos 8'hFF.
  - All strobes, shot_req, win, lose and both counters 0.
- Outputs are registered except pick_ship, which is combinational from state and click.
- Latency:
  - Click to pick_place: 1 cycle.
  - pick_place to shot_req: 1 cycle.
  - shot_ack to the counter/state update: next edge.
  - mouse_position is stale up to one frame.
- A click and a frame_tick in the same cycle use the pre-tick mouse_position.
- shot_req and shot_ack in the same cycle complete the handshake; shot_req drops the next cycle.
- start_button held through IDLE for many cycles enters PLACE once; in PLACE start_button is ignored.
- rst asserted mid-SHOT drops shot_req on the next edge; no partial counter update occurs.

## Configuration
- AIM_TIMEOUT_EN defined:
  - A frame counter runs in AIM and clears on entry.
  - After TIMEOUT_FRAMES frame_ticks without an on-board click, the block enters SHOT with shot_pos = 8'hFF (pass).
  - A pass acknowledged with shot_hit = 0 → WAIT.
- AIM_TIMEOUT_EN undefined: no counter; AIM waits indefinitely.

## Test plan
- Pointer (96,193) at frame_tick → mouse_position 8'h00; (415,512) → 8'h99; (95,200) → 8'hFF; (416,200) → 8'hFF.
- start_button, ship_count ramped 0→10 with first_player=1, click at cell 8'h34 → PLACE, AIM, pick_place one cycle, shot_req one cycle later with shot_pos 8'h34.
- shot_req answered with shot_hit=1 after 5 cycles → hits_mine 1, back to AIM; a miss → WAIT; then opp_shot_valid with opp_shot_hit=0 → AIM.
- HITS_TO_WIN=2: two acknowledged hits → WIN, win=1, state_led 1111; start_button → IDLE with counters cleared.
- rst during SHOT with shot_req=1 → next cycle IDLE, shot_req 0, shot_pos 8'hFF.
- AIM_TIMEOUT_EN, TIMEOUT_FRAMES=3, no click → after 3 frame_ticks shot_req with shot_pos 8'hFF; ack with hit=0 → WAIT.
